// File: rtl/regfile_pkg.sv
// Shared register-file types and the read-bypass priority rule, reusable by
// other register files (e.g. a future FP file).
package regfile_pkg;

  localparam int DEF_NREGS = 32;
  localparam int DEF_AW    = $clog2(DEF_NREGS);
  localparam int ZERO_REG  = 0;

  typedef logic [DEF_AW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    SEL_ZERO,
    SEL_WB,
    SEL_WA,
    SEL_REG
  } byp_sel_e;

  // r0 first, then the load port, then the ALU port, then stored state.
  function automatic byp_sel_e bypass_sel(input logic is_zero,
                                          input logic hit_b,
                                          input logic hit_a);
    if (is_zero)    return SEL_ZERO;
    else if (hit_b) return SEL_WB;
    else if (hit_a) return SEL_WA;
    else            return SEL_REG;
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port: combinational bypass mux plus RAW hazard flag, zero latency.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic [AW-1:0]         addr_i,
  input  logic                  wa_en_i,
  input  logic [AW-1:0]         wa_addr_i,
  input  logic [XLEN-1:0]       wa_data_i,
  input  logic                  wb_en_i,
  input  logic [AW-1:0]         wb_addr_i,
  input  logic [XLEN-1:0]       wb_data_i,
  input  logic [NREGS*XLEN-1:0] rf_i,
  input  logic [NREGS-1:0]      busy_i,
  output logic [XLEN-1:0]       data_o,
  output logic                  busy_o
);

  logic     is_zero;
  logic     hit_a;
  logic     hit_b;
  byp_sel_e sel;

  assign is_zero = (addr_i == AW'(ZERO_REG));
  assign hit_a   = wa_en_i && (wa_addr_i == addr_i);
  assign hit_b   = wb_en_i && (wb_addr_i == addr_i);
  assign sel     = bypass_sel(is_zero, hit_b, hit_a);

  always_comb begin
    data_o = '0;
    case (sel)
      SEL_ZERO: data_o = '0;
      SEL_WB:   data_o = wb_data_i;
      SEL_WA:   data_o = wa_data_i;
      SEL_REG:  data_o = rf_i[int'(addr_i)*XLEN +: XLEN];
      default:  data_o = '0;
    endcase
  end

  // A source being written this cycle is bypassed, so it is not a hazard.
  assign busy_o = busy_i[addr_i] && !hit_a && !hit_b && !is_zero;

endmodule

// File: rtl/regfile_sb.sv
// Register file with two write ports, N bypassed read ports and a busy scoreboard.
// Reads and hazard flags are combinational; writes and reservations land on the clock edge.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NRD*$clog2(NREGS)-1:0] rd_addr_i,
  output logic [NRD*XLEN-1:0]         rd_data_o,
  output logic [NRD-1:0]              rd_busy_o,
  input  logic                        wa_en_i,
  input  logic [$clog2(NREGS)-1:0]    wa_addr_i,
  input  logic [XLEN-1:0]             wa_data_i,
  input  logic                        wb_en_i,
  input  logic [$clog2(NREGS)-1:0]    wb_addr_i,
  input  logic [XLEN-1:0]             wb_data_i,
  input  logic                        iss_en_i,
  input  logic [$clog2(NREGS)-1:0]    iss_addr_i,
  output logic [NREGS-1:0]            busy_vec_o
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]       regs_q [NREGS];
  logic [XLEN-1:0]       regs_d [NREGS];
  logic [NREGS-1:0]      busy_q;
  logic [NREGS-1:0]      busy_d;
  logic [NREGS*XLEN-1:0] rf_flat;

  // Port B is applied last so a load wins a same-address collision.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int i = 1; i < NREGS; i++) begin
      if (wa_en_i && (wa_addr_i == AW'(i))) regs_d[i] = wa_data_i;
      if (wb_en_i && (wb_addr_i == AW'(i))) regs_d[i] = wb_data_i;
      if (iss_en_i && (iss_addr_i == AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if ((wa_en_i && (wa_addr_i == AW'(i))) ||
                   (wb_en_i && (wb_addr_i == AW'(i)))) begin
        busy_d[i] = 1'b0;
      end
    end
    regs_d[ZERO_REG] = '0;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rf_flat = '0;
    for (int i = 0; i < NREGS; i++) rf_flat[i*XLEN +: XLEN] = regs_q[i];
  end

  assign busy_vec_o = busy_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rdport #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
    ) u_rdport (
      .addr_i    (rd_addr_i[k*AW +: AW]),
      .wa_en_i   (wa_en_i),
      .wa_addr_i (wa_addr_i),
      .wa_data_i (wa_data_i),
      .wb_en_i   (wb_en_i),
      .wb_addr_i (wb_addr_i),
      .wb_data_i (wb_data_i),
      .rf_i      (rf_flat),
      .busy_i    (busy_q),
      .data_o    (rd_data_o[k*XLEN +: XLEN]),
      .busy_o    (rd_busy_o[k])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, reset/sweep sequences, and
// randomized traffic against an array-based reference model.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  // Default instance: XLEN=32, NREGS=32, NRD=2
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wa_en, wb_en, iss_en;
  logic [4:0]  wa_addr, wb_addr, iss_addr;
  logic [31:0] wa_data, wb_data;
  logic [31:0] busy_vec;

  // Sweep instance: XLEN=64, NREGS=16, NRD=4
  logic [15:0]  rd_addr2;
  logic [255:0] rd_data2;
  logic [3:0]   rd_busy2;
  logic         wa_en2, wb_en2, iss_en2;
  logic [3:0]   wa_addr2, wb_addr2, iss_addr2;
  logic [63:0]  wa_data2, wb_data2;
  logic [15:0]  busy_vec2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst(rst),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .wa_en_i(wa_en), .wa_addr_i(wa_addr), .wa_data_i(wa_data),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .iss_en_i(iss_en), .iss_addr_i(iss_addr), .busy_vec_o(busy_vec)
  );

  regfile_sb #(.XLEN(64), .NREGS(16), .NRD(4)) dut2 (
    .clk(clk), .rst(rst),
    .rd_addr_i(rd_addr2), .rd_data_o(rd_data2), .rd_busy_o(rd_busy2),
    .wa_en_i(wa_en2), .wa_addr_i(wa_addr2), .wa_data_i(wa_data2),
    .wb_en_i(wb_en2), .wb_addr_i(wb_addr2), .wb_data_i(wb_data2),
    .iss_en_i(iss_en2), .iss_addr_i(iss_addr2), .busy_vec_o(busy_vec2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  typedef struct {
    logic        wa_en;  logic [4:0] wa_addr;  logic [31:0] wa_data;
    logic        wb_en;  logic [4:0] wb_addr;  logic [31:0] wb_data;
    logic        iss_en; logic [4:0] iss_addr;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0, e1;
    logic [1:0]  ebusy;
    logic [31:0] ebv;
  } vec_t;

  function automatic vec_t mk(logic wae, logic [4:0] waa, logic [31:0] wad,
                              logic wbe, logic [4:0] wba, logic [31:0] wbd,
                              logic ie, logic [4:0] ia,
                              logic [4:0] r0, logic [4:0] r1,
                              logic [31:0] x0, logic [31:0] x1,
                              logic [1:0] xb, logic [31:0] xbv);
    vec_t v;
    v.wa_en = wae; v.wa_addr = waa; v.wa_data = wad;
    v.wb_en = wbe; v.wb_addr = wba; v.wb_data = wbd;
    v.iss_en = ie; v.iss_addr = ia;
    v.ra0 = r0; v.ra1 = r1; v.e0 = x0; v.e1 = x1; v.ebusy = xb; v.ebv = xbv;
    return v;
  endfunction

  // Reference model state
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  function automatic logic [31:0] m_read(logic [4:0] a);
    if (a == 0)                     return 32'h0;
    if (wb_en && wb_addr == a)      return wb_data;
    if (wa_en && wa_addr == a)      return wa_data;
    return m_regs[a];
  endfunction

  function automatic logic m_hazard(logic [4:0] a);
    return (a != 0) && m_busy[a] && !(wa_en && wa_addr == a) && !(wb_en && wb_addr == a);
  endfunction

  function automatic logic [4:0] rnd_addr();
    return ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  task automatic idle();
    wa_en = 0; wa_addr = 0; wa_data = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    iss_en = 0; iss_addr = 0;
  endtask

  task automatic idle2();
    wa_en2 = 0; wa_addr2 = 0; wa_data2 = 0;
    wb_en2 = 0; wb_addr2 = 0; wb_data2 = 0;
    iss_en2 = 0; iss_addr2 = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [13];
    idle(); idle2();
    rd_addr = {5'd7, 5'd5};
    rd_addr2 = 16'h4321;

    // Reset held: everything reads zero
    #2;
    chk("rst_rd0", rd_data[31:0], 32'h0);
    chk("rst_rd1", rd_data[63:32], 32'h0);
    chk("rst_busyvec", busy_vec, 32'h0);
    chk("rst_rdbusy", rd_busy, 2'b00);
    repeat (2) @(negedge clk);
    rst = 0;

    tbl[0]  = mk(1,0,32'h1234,     0,0,0,            1,0, 0,0, 0,0,                    2'b00, 32'h0);
    tbl[1]  = mk(0,0,0,            0,0,0,            0,0, 0,0, 0,0,                    2'b00, 32'h0);
    tbl[2]  = mk(1,7,32'hAAAA0000, 1,7,32'h5555FFFF, 0,0, 7,7, 32'h5555FFFF,32'h5555FFFF, 2'b00, 32'h0);
    tbl[3]  = mk(0,0,0,            0,0,0,            0,0, 7,0, 32'h5555FFFF,0,         2'b00, 32'h0);
    tbl[4]  = mk(0,0,0,            0,0,0,            1,9, 9,7, 0,32'h5555FFFF,         2'b00, 32'h0);
    tbl[5]  = mk(0,0,0,            0,0,0,            0,0, 9,9, 0,0,                    2'b11, 32'h200);
    tbl[6]  = mk(1,9,32'h42,       0,0,0,            0,0, 9,9, 32'h42,32'h42,          2'b00, 32'h200);
    tbl[7]  = mk(0,0,0,            0,0,0,            0,0, 9,9, 32'h42,32'h42,          2'b00, 32'h0);
    tbl[8]  = mk(0,0,0,            0,0,0,            1,3, 3,3, 0,0,                    2'b00, 32'h0);
    tbl[9]  = mk(0,0,0,            1,3,32'h77,       1,3, 3,3, 32'h77,32'h77,          2'b00, 32'h8);
    tbl[10] = mk(0,0,0,            0,0,0,            0,0, 3,9, 32'h77,32'h42,          2'b01, 32'h8);
    tbl[11] = mk(0,0,0,            1,5,32'hDEADBEEF, 1,5, 5,3, 32'hDEADBEEF,32'h77,    2'b10, 32'h8);
    tbl[12] = mk(0,0,0,            0,0,0,            0,0, 5,3, 32'hDEADBEEF,32'h77,    2'b11, 32'h28);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      wa_en = tbl[i].wa_en; wa_addr = tbl[i].wa_addr; wa_data = tbl[i].wa_data;
      wb_en = tbl[i].wb_en; wb_addr = tbl[i].wb_addr; wb_data = tbl[i].wb_data;
      iss_en = tbl[i].iss_en; iss_addr = tbl[i].iss_addr;
      rd_addr = {tbl[i].ra1, tbl[i].ra0};
      #1;
      chk($sformatf("vec%0d_rd0", i), rd_data[31:0], tbl[i].e0);
      chk($sformatf("vec%0d_rd1", i), rd_data[63:32], tbl[i].e1);
      chk($sformatf("vec%0d_rdbusy", i), rd_busy, tbl[i].ebusy);
      chk($sformatf("vec%0d_busyvec", i), busy_vec, tbl[i].ebv);
    end

    // Asynchronous reset mid-cycle drops data and pending reservations
    @(negedge clk);
    idle();
    rd_addr = {5'd3, 5'd5};
    #1;
    chk("prerst_r5", rd_data[31:0], 32'hDEADBEEF);
    #1 rst = 1;
    #1;
    chk("midrst_r5", rd_data[31:0], 32'h0);
    chk("midrst_r3", rd_data[63:32], 32'h0);
    chk("midrst_busyvec", busy_vec, 32'h0);
    chk("midrst_rdbusy", rd_busy, 2'b00);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_busy = 32'h0;

    // Randomized traffic against the reference model
    for (int c = 0; c < 300; c++) begin
      logic [4:0] a0, a1;
      @(negedge clk);
      wa_en = 1'($urandom_range(0, 1)); wa_addr = rnd_addr(); wa_data = $urandom;
      wb_en = 1'($urandom_range(0, 1)); wb_addr = rnd_addr(); wb_data = $urandom;
      iss_en = 1'($urandom_range(0, 1)); iss_addr = rnd_addr();
      a0 = rnd_addr(); a1 = rnd_addr();
      rd_addr = {a1, a0};
      #1;
      chk($sformatf("rnd%0d_rd0", c), rd_data[31:0], m_read(a0));
      chk($sformatf("rnd%0d_rd1", c), rd_data[63:32], m_read(a1));
      chk($sformatf("rnd%0d_rdbusy", c), rd_busy, {m_hazard(a1), m_hazard(a0)});
      chk($sformatf("rnd%0d_busyvec", c), busy_vec, m_busy);
      if (wa_en) m_regs[wa_addr] = wa_data;
      if (wb_en) m_regs[wb_addr] = wb_data;
      m_regs[0] = 32'h0;
      if (wa_en) m_busy[wa_addr] = 1'b0;
      if (wb_en) m_busy[wb_addr] = 1'b0;
      if (iss_en) m_busy[iss_addr] = 1'b1;
      m_busy[0] = 1'b0;
    end
    @(negedge clk);
    idle();

    // Wide, four-port configuration
    @(negedge clk);
    wa_en2 = 1; wa_addr2 = 4'd15; wa_data2 = 64'hFFFF_0000_FFFF_0000;
    wb_en2 = 1; wb_addr2 = 4'd1;  wb_data2 = 64'h1111_2222_3333_4444;
    @(negedge clk);
    wa_en2 = 1; wa_addr2 = 4'd2;  wa_data2 = 64'h0123_4567_89AB_CDEF;
    wb_en2 = 1; wb_addr2 = 4'd3;  wb_data2 = 64'hFEDC_BA98_7654_3210;
    iss_en2 = 1; iss_addr2 = 4'd14;
    rd_addr2 = {4'd3, 4'd2, 4'd1, 4'd15};
    #1;
    chk("w_byp_p0", rd_data2[0*64 +: 64], 64'hFFFF_0000_FFFF_0000);
    chk("w_byp_p1", rd_data2[1*64 +: 64], 64'h1111_2222_3333_4444);
    chk("w_byp_p2", rd_data2[2*64 +: 64], 64'h0123_4567_89AB_CDEF);
    chk("w_byp_p3", rd_data2[3*64 +: 64], 64'hFEDC_BA98_7654_3210);
    @(negedge clk);
    idle2();
    #1;
    chk("w_p0", rd_data2[0*64 +: 64], 64'hFFFF_0000_FFFF_0000);
    chk("w_p1", rd_data2[1*64 +: 64], 64'h1111_2222_3333_4444);
    chk("w_p2", rd_data2[2*64 +: 64], 64'h0123_4567_89AB_CDEF);
    chk("w_p3", rd_data2[3*64 +: 64], 64'hFEDC_BA98_7654_3210);
    chk("w_rdbusy", rd_busy2, 4'b0000);
    chk("w_busyvec", busy_vec2, 16'h4000);
    rd_addr2 = {4'd14, 4'd0, 4'd1, 4'd15};
    #1;
    chk("w_r0", rd_data2[2*64 +: 64], 64'h0);
    chk("w_rdbusy14", rd_busy2, 4'b1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
